// File: rtl/kernel_product_sched.sv
// Round-robin issue scheduler for the 7x7 kernel product unit: grants one requester per cycle,
// tags each issue through a fixed-latency pipeline and tracks per-requester result-buffer credits.
module kernel_product_sched #(
   parameter int NUM_REQ   = 2,
   parameter int LATENCY   = 2,
   parameter int RES_DEPTH = 4,
   localparam int SELW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW       = $clog2(RES_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   output logic               mul_valid,
   output logic [SELW-1:0]    mul_sel,
   input  logic               mul_result_valid,
   output logic [NUM_REQ-1:0] res_valid,
   input  logic [NUM_REQ-1:0] res_pop,
   output logic               busy,
   output logic               err
);

   logic [SELW-1:0]                rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0][CW-1:0]     credit_q, credit_d;
   logic [LATENCY-1:0]             stg_valid_q, stg_valid_d;
   logic [LATENCY-1:0][SELW-1:0]   stg_id_q, stg_id_d;
   logic                           err_q, err_d;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic               found;
   logic [SELW-1:0]    win;
   logic [SELW-1:0]    idx;

   // Grant: first eligible requester at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = enable & req_valid[i] & (credit_q[i] != '0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = SELW'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found) begin
         grant[win] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign mul_valid = found;
   assign mul_sel   = win;
   assign busy      = |stg_valid_q;
   assign err       = err_q;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         res_valid[k] = stg_valid_q[LATENCY-1] & mul_result_valid &
                        (stg_id_q[LATENCY-1] == SELW'(k));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (found) begin
         rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      end

      // The product unit never stalls, so the tag pipeline shifts every cycle.
      stg_valid_d[0] = found;
      stg_id_d[0]    = win;
      for (int i = 1; i < LATENCY; i++) begin
         stg_valid_d[i] = stg_valid_q[i-1];
         stg_id_d[i]    = stg_id_q[i-1];
      end

      err_d = err_q | (mul_result_valid != stg_valid_q[LATENCY-1]);

      // Pop and issue on the same requester cancel; a pop into a full credit pool is dropped.
      for (int k = 0; k < NUM_REQ; k++) begin
         credit_d[k] = credit_q[k];
         if (res_pop[k] && !grant[k]) begin
            if (credit_q[k] == CW'(RES_DEPTH)) begin
               err_d = 1'b1;
            end else begin
               credit_d[k] = credit_q[k] + 1'b1;
            end
         end else if (!res_pop[k] && grant[k]) begin
            credit_d[k] = credit_q[k] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         stg_valid_q <= '0;
         stg_id_q    <= '0;
         err_q       <= 1'b0;
         for (int k = 0; k < NUM_REQ; k++) begin
            credit_q[k] <= CW'(RES_DEPTH);
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         stg_valid_q <= stg_valid_d;
         stg_id_q    <= stg_id_d;
         err_q       <= err_d;
         credit_q    <= credit_d;
      end
   end

endmodule

// File: tb/tb_kernel_product_sched.sv
// Directed bench for kernel_product_sched (NUM_REQ=2, LATENCY=2, RES_DEPTH=4) with a
// two-stage product-unit model whose output can be forced high or suppressed.
module tb_kernel_product_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] res_pop = 2'b00;
   logic       inject = 1'b0;
   logic       drop = 1'b0;

   logic [1:0] req_ready;
   logic       mul_valid;
   logic [0:0] mul_sel;
   logic       mul_result_valid;
   logic [1:0] res_valid;
   logic       busy;
   logic       err;

   logic [1:0] pu_q;
   logic [7:0] obs;

   int n_checks = 0;
   int n_errors = 0;

   kernel_product_sched #(.NUM_REQ(2), .LATENCY(2), .RES_DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .mul_valid        (mul_valid),
      .mul_sel          (mul_sel),
      .mul_result_valid (mul_result_valid),
      .res_valid        (res_valid),
      .res_pop          (res_pop),
      .busy             (busy),
      .err              (err)
   );

   always #5 clk = ~clk;

   // Product unit: two-cycle valid delay, reset together with the scheduler.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pu_q <= 2'b00;
      else        pu_q <= {pu_q[0], mul_valid};
   end
   assign mul_result_valid = (pu_q[1] & ~drop) | inject;

   // {req_ready[1:0], mul_valid, mul_sel, res_valid[1:0], busy, err}
   assign obs = {req_ready, mul_valid, mul_sel, res_valid, busy, err};

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; req_valid = 2'b00; res_pop = 2'b00;
      inject = 1'b0; drop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; req_valid = 2'b00; res_pop = 2'b00;
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL reset_hold: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; enable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #2;
         if (obs !== 8'b0) begin n_errors++; $display("FAIL reset_idle_c%0d: obs=%b exp=%b", c, obs, 8'b0); end
         n_checks++;
         next_cycle();
      end
   endtask

   task automatic test_req0_credits();
      logic [7:0] exp;
      do_reset();
      enable = 1'b1; req_valid = 2'b01;
      for (int c = 0; c < 8; c++) begin
         exp = {(c < 4) ? 2'b01 : 2'b00, c < 4, 1'b0,
                (c >= 2 && c < 6) ? 2'b01 : 2'b00, (c >= 1 && c < 6), 1'b0};
         #2;
         if (obs !== exp) begin n_errors++; $display("FAIL req0_c%0d: obs=%b exp=%b", c, obs, exp); end
         n_checks++;
         next_cycle();
      end
      res_pop = 2'b01;
      #2;
      if (obs !== 8'b00_0_0_00_0_0) begin n_errors++; $display("FAIL req0_pop: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      next_cycle();
      res_pop = 2'b00;
      #2;
      if (obs !== 8'b01_1_0_00_0_0) begin n_errors++; $display("FAIL req0_reissue: obs=%b exp=%b", obs, 8'b01100000); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b00_0_0_00_1_0) begin n_errors++; $display("FAIL req0_restall: obs=%b exp=%b", obs, 8'b00000010); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b00_0_0_01_1_0) begin n_errors++; $display("FAIL req0_reres: obs=%b exp=%b", obs, 8'b00000110); end
      n_checks++;
      req_valid = 2'b00;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      logic [1:0] g;
      do_reset();
      enable = 1'b1; req_valid = 2'b11;
      for (int c = 0; c < 8; c++) begin
         g = (c % 2 == 0) ? 2'b01 : 2'b10;
         res_pop = g;
         exp = {g, 1'b1, (c % 2 == 1), (c >= 2) ? g : 2'b00, c >= 1, 1'b0};
         #2;
         if (obs !== exp) begin n_errors++; $display("FAIL alt_c%0d: obs=%b exp=%b", c, obs, exp); end
         n_checks++;
         next_cycle();
      end
      req_valid = 2'b00; res_pop = 2'b00;
      #2;
      if (obs !== 8'b00_0_0_01_1_0) begin n_errors++; $display("FAIL alt_tail0: obs=%b exp=%b", obs, 8'b00000110); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b00_0_0_10_1_0) begin n_errors++; $display("FAIL alt_tail1: obs=%b exp=%b", obs, 8'b00001010); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL alt_drained: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      next_cycle();
      // Credits must still be full: exactly four issues to requester 0.
      req_valid = 2'b01;
      for (int c = 0; c < 6; c++) begin
         exp = {(c < 4) ? 2'b01 : 2'b00, c < 4, 1'b0,
                (c >= 2 && c < 6) ? 2'b01 : 2'b00, c >= 1, 1'b0};
         #2;
         if (obs !== exp) begin n_errors++; $display("FAIL alt_credit_c%0d: obs=%b exp=%b", c, obs, exp); end
         n_checks++;
         next_cycle();
      end
      req_valid = 2'b00;
   endtask

   task automatic test_credit_zero_pop();
      logic [7:0] exp;
      do_reset();
      enable = 1'b1; req_valid = 2'b10;
      for (int c = 0; c < 4; c++) begin
         exp = {2'b10, 1'b1, 1'b1, (c >= 2) ? 2'b10 : 2'b00, c >= 1, 1'b0};
         #2;
         if (obs !== exp) begin n_errors++; $display("FAIL zc_issue_c%0d: obs=%b exp=%b", c, obs, exp); end
         n_checks++;
         next_cycle();
      end
      #2;
      if (obs !== 8'b00_0_0_10_1_0) begin n_errors++; $display("FAIL zc_stall: obs=%b exp=%b", obs, 8'b00001010); end
      n_checks++;
      next_cycle();
      res_pop = 2'b10;
      #2;
      if (obs !== 8'b00_0_0_10_1_0) begin n_errors++; $display("FAIL zc_pop: obs=%b exp=%b", obs, 8'b00001010); end
      n_checks++;
      next_cycle();
      res_pop = 2'b00;
      #2;
      if (obs !== 8'b10_1_1_00_0_0) begin n_errors++; $display("FAIL zc_reissue: obs=%b exp=%b", obs, 8'b10110000); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b00_0_0_00_1_0) begin n_errors++; $display("FAIL zc_restall: obs=%b exp=%b", obs, 8'b00000010); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b00_0_0_10_1_0) begin n_errors++; $display("FAIL zc_reres: obs=%b exp=%b", obs, 8'b00001010); end
      n_checks++;
      req_valid = 2'b00;
      next_cycle();
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b1; req_valid = 2'b01;
      #2;
      if (obs !== 8'b01_1_0_00_0_0) begin n_errors++; $display("FAIL en_c0: obs=%b exp=%b", obs, 8'b01100000); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b01_1_0_00_1_0) begin n_errors++; $display("FAIL en_c1: obs=%b exp=%b", obs, 8'b01100010); end
      n_checks++;
      next_cycle();
      enable = 1'b0;
      for (int c = 2; c < 4; c++) begin
         #2;
         if (obs !== 8'b00_0_0_01_1_0) begin n_errors++; $display("FAIL en_off_c%0d: obs=%b exp=%b", c, obs, 8'b00000110); end
         n_checks++;
         next_cycle();
      end
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL en_drained: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      req_valid = 2'b00;
      next_cycle();
   endtask

   task automatic test_err();
      // Stray product valid with nothing in flight.
      do_reset();
      enable = 1'b1;
      inject = 1'b1;
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL err_inject_same: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      next_cycle();
      inject = 1'b0;
      for (int c = 1; c < 6; c++) begin
         #2;
         if (obs !== 8'b00_0_0_00_0_1) begin n_errors++; $display("FAIL err_inject_c%0d: obs=%b exp=%b", c, obs, 8'b00000001); end
         n_checks++;
         next_cycle();
      end
      // Missing product valid for an issued tag.
      do_reset();
      enable = 1'b1; req_valid = 2'b01;
      #2;
      if (obs !== 8'b01_1_0_00_0_0) begin n_errors++; $display("FAIL err_drop_issue: obs=%b exp=%b", obs, 8'b01100000); end
      n_checks++;
      next_cycle();
      req_valid = 2'b00;
      #2;
      if (obs !== 8'b00_0_0_00_1_0) begin n_errors++; $display("FAIL err_drop_c1: obs=%b exp=%b", obs, 8'b00000010); end
      n_checks++;
      next_cycle();
      drop = 1'b1;
      #2;
      if (obs !== 8'b00_0_0_00_1_0) begin n_errors++; $display("FAIL err_drop_c2: obs=%b exp=%b", obs, 8'b00000010); end
      n_checks++;
      next_cycle();
      drop = 1'b0;
      for (int c = 3; c < 6; c++) begin
         #2;
         if (obs !== 8'b00_0_0_00_0_1) begin n_errors++; $display("FAIL err_drop_c%0d: obs=%b exp=%b", c, obs, 8'b00000001); end
         n_checks++;
         next_cycle();
      end
      // Credit return into a full pool.
      do_reset();
      res_pop = 2'b01;
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL err_ovf_same: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      next_cycle();
      res_pop = 2'b00;
      #2;
      if (obs !== 8'b00_0_0_00_0_1) begin n_errors++; $display("FAIL err_ovf_next: obs=%b exp=%b", obs, 8'b00000001); end
      n_checks++;
      do_reset();
      #2;
      if (err !== 1'b0) begin n_errors++; $display("FAIL err_cleared: err=%b exp=0", err); end
      n_checks++;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      do_reset();
      enable = 1'b1; req_valid = 2'b11;
      #2;
      if (obs !== 8'b01_1_0_00_0_0) begin n_errors++; $display("FAIL rm_issue0: obs=%b exp=%b", obs, 8'b01100000); end
      n_checks++;
      next_cycle();
      #2;
      if (obs !== 8'b10_1_1_00_1_0) begin n_errors++; $display("FAIL rm_issue1: obs=%b exp=%b", obs, 8'b10110010); end
      n_checks++;
      next_cycle();
      rst_n = 1'b0; enable = 1'b0; req_valid = 2'b00;
      #2;
      if (obs !== 8'b0) begin n_errors++; $display("FAIL rm_flush: obs=%b exp=%b", obs, 8'b0); end
      n_checks++;
      next_cycle();
      rst_n = 1'b1; enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         if (obs !== 8'b0) begin n_errors++; $display("FAIL rm_quiet_c%0d: obs=%b exp=%b", c, obs, 8'b0); end
         n_checks++;
         next_cycle();
      end
      req_valid = 2'b01;
      for (int c = 0; c < 6; c++) begin
         exp = {(c < 4) ? 2'b01 : 2'b00, c < 4, 1'b0,
                (c >= 2 && c < 6) ? 2'b01 : 2'b00, c >= 1, 1'b0};
         #2;
         if (obs !== exp) begin n_errors++; $display("FAIL rm_credit_c%0d: obs=%b exp=%b", c, obs, exp); end
         n_checks++;
         next_cycle();
      end
      req_valid = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_req0_credits();
      test_back_to_back();
      test_credit_zero_pop();
      test_enable();
      test_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/kernel_product_sched.md
Name: kernel_product_sched

Overview:
- Issue scheduler for the 49-lane 7x7 kernel product datapath. The datapath is fixed-latency, with valid-in/valid-out and no backpressure.
- Arbitrates NUM_REQ kernel-pair requesters onto the single product unit, one issue per cycle, round-robin.
- Drives the unit's input valid and the kernel-mux select. Tags every issue and routes each returning product valid to its owner.
- Per-requester credit counters guarantee that the downstream result buffers never overflow.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LATENCY, 2, product unit latency in cycles, from kernel_valid to product_valid.
- RES_DEPTH, 4, entries in each requester's downstream result buffer. This is the initial credit count (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new issues; in-flight products still drain.
- req_valid  in  NUM_REQ  requester k has a kernel pair ready.
- req_ready  out  NUM_REQ  one-hot grant; issue to k occurs when req_valid[k] & req_ready[k].
- mul_valid  out  1  kernel_valid to the product unit.
- mul_sel  out  SELW=max(1,clog2(NUM_REQ))  index of the granted requester. Steers the kernel_a/kernel_b input mux.
- mul_result_valid  in  1  product_valid from the product unit.
- res_valid  out  NUM_REQ  one-hot; the current product belongs to requester k.
- res_pop  in  NUM_REQ  requester k freed one result-buffer entry (credit return).
- busy  out  1  any issue in flight.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rr_ptr=0, all tag stages invalid, credit[k]=RES_DEPTH, err=0.
  - Every output is 0: req_ready, mul_valid, mul_sel, res_valid, busy, err.
- Eligibility: requester k is eligible when enable & req_valid[k] & credit[k]!=0.
- Grant (combinational from registered state):
  - The first eligible index is searched from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready is the one-hot of the winner; it is all zero if none is eligible.
  - mul_valid = |req_ready. mul_sel = winner index when mul_valid, else 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On issue to requester w (clock edge):
  - rr_ptr <= (w+1) mod NUM_REQ. rr_ptr holds when there is no issue.
  - credit[w] decrements.
  - Tag pipeline stage 0 <= {valid=1, id=w}.
- Tag pipeline:
  - LATENCY registered stages, shifted every cycle unconditionally. The pipeline is never stalled, because the product unit has no stall.
  - res_valid[k] = stage[LATENCY-1].valid & id==k & mul_result_valid.
  - An issue at cycle T therefore yields res_valid at cycle T+LATENCY, aligned with product_valid.
- Credits:
  - credit[k] += res_pop[k]; credit[k] -= issue_k. Simultaneous pop and issue on the same k leaves the count unchanged.
  - Counter width is clog2(RES_DEPTH+1).
  - A pop with credit[k]==RES_DEPTH and no same-cycle issue to k is ignored, and sets err.
- err is set (sticky until reset) on any of:
  - mul_result_valid != stage[LATENCY-1].valid;
  - credit overflow pop.
- busy = OR of all tag-stage valids.
- enable deassert mid-stream: no issue from the next cycle on. Outstanding tags drain normally and busy falls LATENCY cycles after the last issue.
- Reset mid-operation: tags and credits are discarded immediately and credits return to RES_DEPTH. Any product_valid arriving afterwards with no tag sets err. The upstream product unit must be reset together with this block.
- Throughput: one issue per cycle sustained while credits allow. No bubble is inserted between different requesters.

Test Plan:
- Reset release, req_valid=0 -> all outputs 0 and credit=4 for both requesters. No mul_valid for 10 cycles.
- Req0 only, valid held, no pops -> mul_valid high on 4 consecutive cycles with mul_sel=0, then stall. res_valid[0] appears 2 cycles after each issue. After one res_pop[0], exactly one more issue follows on the next cycle.
- Req0 and req1 both held, pops each cycle they are issued -> grants alternate 0,1,0,1 starting at 0. Each res_valid one-hot matches the issued id 2 cycles later.
- Req1 at credit=0 with res_pop[1] and req_valid[1] in the same cycle -> issue to req1 on the following cycle. With credit=4, a simultaneous issue and pop keeps credit at 4.
- Inject mul_result_valid with no tag in flight, and separately drop it for an issued tag -> err rises the next cycle and stays 1 until rst_n.
- Issue 2 products, assert rst_n=0 mid-flight -> outputs zero immediately, busy=0, credits=4, no res_valid pulses for the discarded tags.
